// File: rtl/convo_window_3x3_if.sv
// Stream interface for the 3x3 window generator.
//   Data_In / Valid_In       : raster-order pixel stream into the window block
//   Window0..Window8         : 3x3 window, row-major, Window0 top-left
//   Valid_Out                : Window0..8 hold one complete window
//   Frame_Done               : one-cycle pulse with the window of the last frame pixel
// Modports: master drives the pixel stream and consumes windows; slave is the window block.
interface convo_window_3x3_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] Data_In;
    logic                  Valid_In;
    logic [DATA_WIDTH-1:0] Window0;
    logic [DATA_WIDTH-1:0] Window1;
    logic [DATA_WIDTH-1:0] Window2;
    logic [DATA_WIDTH-1:0] Window3;
    logic [DATA_WIDTH-1:0] Window4;
    logic [DATA_WIDTH-1:0] Window5;
    logic [DATA_WIDTH-1:0] Window6;
    logic [DATA_WIDTH-1:0] Window7;
    logic [DATA_WIDTH-1:0] Window8;
    logic                  Valid_Out;
    logic                  Frame_Done;

    modport master (
        output Data_In, Valid_In,
        input  Window0, Window1, Window2, Window3, Window4, Window5, Window6, Window7, Window8,
        input  Valid_Out, Frame_Done
    );

    modport slave (
        input  Data_In, Valid_In,
        output Window0, Window1, Window2, Window3, Window4, Window5, Window6, Window7, Window8,
        output Valid_Out, Frame_Done
    );
endinterface

// File: rtl/convo_window_3x3.sv
// 3x3 sliding-window generator for a raster-order pixel stream.
// Two IMG_WIDTH-deep shift-register line buffers supply rows r-1 and r-2; a 3x3 register
// window shifts left on every accepted pixel. Pixel data is passed through bit-exact.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (counters, window, Valid_Out, Frame_Done)
//   bus : convo_window_3x3_if slave (Data_In/Valid_In in, Window0..8/Valid_Out/Frame_Done out)
module convo_window_3x3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28
) (
    input  logic               clk,
    input  logic               rst,
    convo_window_3x3_if.slave  bus
);
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_win [9];
    logic                  r_valid;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_win_ok;
    logic [DATA_WIDTH-1:0] w_lb1_out;
    logic [DATA_WIDTH-1:0] w_lb2_out;

    assign w_accept   = bus.Valid_In;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    // Only full windows inside the current row region; cols 0/1 would straddle rows.
    assign w_win_ok   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    // Tail of each line buffer is the same column, one and two rows up.
    assign w_lb1_out  = r_lb1[IMG_WIDTH-1];
    assign w_lb2_out  = r_lb2[IMG_WIDTH-1];

    // Raster position of the pixel about to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Line buffers carry no reset: rows 0 and 1 refill them before any window is flagged.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[0] <= bus.Data_In;
            r_lb2[0] <= w_lb1_out;
            for (int unsigned i = 1; i < IMG_WIDTH; i++) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb2[i] <= r_lb2[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_accept && w_win_ok;
            r_done  <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb2_out;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb1_out;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= bus.Data_In;
            end
        end
    end

    assign bus.Window0    = r_win[0];
    assign bus.Window1    = r_win[1];
    assign bus.Window2    = r_win[2];
    assign bus.Window3    = r_win[3];
    assign bus.Window4    = r_win[4];
    assign bus.Window5    = r_win[5];
    assign bus.Window6    = r_win[6];
    assign bus.Window7    = r_win[7];
    assign bus.Window8    = r_win[8];
    assign bus.Valid_Out  = r_valid;
    assign bus.Frame_Done = r_done;
endmodule
